// File: rtl/tb_engine_if.sv
// Edit-operation stream from the traceback engine to its consumer.
// The engine drives valid/op and the consumer answers with ready.
interface tb_engine_if;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op;

    modport master (
        output op_valid,
        output op,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op,
        output op_ready
    );
endinterface

// File: rtl/tb_engine.sv
// Traceback engine: walks the two-piece affine direction memory from the
// end cell and streams the alignment path as M/I/D edit operations.
module tb_engine #(
    parameter int N                = 4,
    parameter int LOG_N            = 2,
    parameter int DIRECTION_WIDTH  = 7,
    parameter int ADDRESS_WIDTH    = 10,
    parameter int MEM_AMOUNT_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic                          tb_valid,
    input  logic                          array_num,
    output logic                          tb_busy,
    output logic [MEM_AMOUNT_WIDTH-1:0]   mem_block_num,
    output logic [ADDRESS_WIDTH-1:0]      row_num,
    input  logic [N*DIRECTION_WIDTH-1:0]  row_k0,
    input  logic [N*DIRECTION_WIDTH-1:0]  row_k1,
    input  logic [ADDRESS_WIDTH-1:0]      tb_x,
    input  logic [ADDRESS_WIDTH-1:0]      tb_y,
    tb_engine_if.master                   op_if,
    output logic                          aln_done,
    output logic                          aln_array
);

    localparam int DW = DIRECTION_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam int MW = MEM_AMOUNT_WIDTH;

    localparam logic [1:0] OP_M = 2'b00;
    localparam logic [1:0] OP_I = 2'b01;
    localparam logic [1:0] OP_D = 2'b10;

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, EVAL, EMIT, DONE
    } state_t;

    // Encoding matches the H-source field so a switch is a plain cast.
    typedef enum logic [2:0] {
        MH, ME1, MF1, ME2, MF2
    } mat_t;

    state_t             state;
    mat_t               mat;
    logic [AW-1:0]      x;
    logic [AW-1:0]      y;
    logic               arr;
    logic [N*DW-1:0]    buf0;
    logic [N*DW-1:0]    buf1;
    logic               v0;
    logic               v1;

    logic [LOG_N-1:0]   lane;
    logic [DW-1:0]      d;
    logic [2:0]         src;
    logic               ext;
    logic               hs;

    function automatic logic [MW-1:0] blk_of(
        input logic [AW-1:0] v
    );
        logic [AW-1:0] s;
        s = v >> LOG_N;
        return s[MW-1:0];
    endfunction

    assign lane = y[LOG_N-1:0];
    assign src  = d[2:0];
    assign hs   = op_if.op_valid && op_if.op_ready;

    always_comb begin
        d = '0;
        for (int l = 0; l < N; l++) begin
            if (lane == l[LOG_N-1:0])
                d = buf0[l*DW +: DW];
        end
    end

    always_comb begin
        ext = 1'b0;
        unique case (1'b1)
            mat == ME1: ext = d[3];
            mat == MF1: ext = d[4];
            mat == ME2: ext = d[5];
            mat == MF2: ext = d[6];
            default:    ext = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state          <= IDLE;
            mat            <= MH;
            x              <= '0;
            y              <= '0;
            arr            <= 1'b0;
            buf0           <= '0;
            buf1           <= '0;
            v0             <= 1'b0;
            v1             <= 1'b0;
            tb_busy        <= 1'b0;
            mem_block_num  <= '0;
            row_num        <= '0;
            op_if.op_valid <= 1'b0;
            op_if.op       <= OP_M;
            aln_done       <= 1'b0;
            aln_array      <= 1'b0;
        end else begin
            aln_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tb_valid) begin
                        x             <= tb_x;
                        y             <= tb_y;
                        arr           <= array_num;
                        mat           <= MH;
                        tb_busy       <= 1'b1;
                        mem_block_num <= blk_of(tb_y);
                        row_num       <= tb_x;
                        state         <= READ;
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    buf0  <= row_k0;
                    buf1  <= row_k1;
                    v0    <= 1'b1;
                    v1    <= 1'b1;
                    state <= EVAL;
                end
                EVAL: begin
                    if (!v0) begin
                        state <= READ;
                    end else if (mat == MH) begin
                        unique case (1'b1)
                            src == 3'd0: begin
                                op_if.op       <= OP_M;
                                op_if.op_valid <= 1'b1;
                                state          <= EMIT;
                            end
                            src >= 3'd1 && src <= 3'd4: begin
                                mat <= mat_t'(src);
                            end
                            default: begin
                                aln_done  <= 1'b1;
                                aln_array <= arr;
                                tb_busy   <= 1'b0;
                                state     <= DONE;
                            end
                        endcase
                    end else begin
                        op_if.op <= (mat == ME1 || mat == ME2)
                                    ? OP_I : OP_D;
                        op_if.op_valid <= 1'b1;
                        mat            <= ext ? mat : MH;
                        state          <= EMIT;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        op_if.op_valid <= 1'b0;
                        // Zero checks guarantee the walk never wraps.
                        if ((op_if.op != OP_D && x == '0) ||
                            (op_if.op != OP_I && y == '0)) begin
                            aln_done  <= 1'b1;
                            aln_array <= arr;
                            tb_busy   <= 1'b0;
                            state     <= DONE;
                        end else if (op_if.op != OP_D) begin
                            x       <= x - 1'b1;
                            row_num <= x - 1'b1;
                            v0      <= 1'b0;
                            v1      <= 1'b0;
                            state   <= READ;
                            if (op_if.op == OP_M) begin
                                y             <= y - 1'b1;
                                mem_block_num <= blk_of(y - 1'b1);
                            end else begin
                                mem_block_num <= blk_of(y);
                            end
                        end else begin
                            y <= y - 1'b1;
                            if (lane != '0) begin
                                state <= EVAL;
                            end else if (v1) begin
                                buf0  <= buf1;
                                v1    <= 1'b0;
                                state <= EVAL;
                            end else begin
                                v0            <= 1'b0;
                                mem_block_num <= blk_of(y - 1'b1);
                                row_num       <= x;
                                state         <= READ;
                            end
                        end
                    end
                end
                DONE: begin
                    aln_array <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_engine.sv
// Directed bench for tb_engine: a registered direction-memory model and
// hand-computed op sequences for each walk.
module tb_tb_engine;

    localparam int N  = 4;
    localparam int DW = 7;
    localparam int AW = 10;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          tb_valid = 1'b0;
    logic          array_num = 1'b0;
    logic          tb_busy;
    logic [MW-1:0] mem_block_num;
    logic [AW-1:0] row_num;
    logic [N*DW-1:0] row_k0;
    logic [N*DW-1:0] row_k1;
    logic [AW-1:0] tb_x = '0;
    logic [AW-1:0] tb_y = '0;
    logic          aln_done;
    logic          aln_array;

    tb_engine_if op_if();

    tb_engine #(
        .N(N), .LOG_N(2), .DIRECTION_WIDTH(DW),
        .ADDRESS_WIDTH(AW), .MEM_AMOUNT_WIDTH(MW)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .tb_valid(tb_valid),
        .array_num(array_num),
        .tb_busy(tb_busy),
        .mem_block_num(mem_block_num),
        .row_num(row_num),
        .row_k0(row_k0),
        .row_k1(row_k1),
        .tb_x(tb_x),
        .tb_y(tb_y),
        .op_if(op_if),
        .aln_done(aln_done),
        .aln_array(aln_array)
    );

    always #5 clk = ~clk;

    // Direction memory indexed [y][x]; 16x16 cells cover every walk.
    logic [DW-1:0] dm [0:15][0:15];

    function automatic logic [DW-1:0] rd(
        input int blk, input int l, input int xa
    );
        int yy;
        yy = (blk & 15) * N + l;
        if (yy < 16 && xa < 16)
            return dm[yy[3:0]][xa[3:0]];
        return '0;
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < N; l++) begin
            row_k0[l*DW +: DW] <= rd(int'(mem_block_num), l,
                                     int'(row_num));
            row_k1[l*DW +: DW] <= rd(int'(mem_block_num) - 1, l,
                                     int'(row_num));
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0] got[$];
    int         rows[$];
    bit         done_seen;
    bit         done_arr;
    int         done_cyc;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++)
                dm[yy][xx] = '0;
    endtask

    task automatic start(input int xs, input int ys, input bit a);
        @(negedge clk);
        tb_x      = AW'(xs);
        tb_y      = AW'(ys);
        array_num = a;
        tb_valid  = 1'b1;
        @(negedge clk);
        tb_valid  = 1'b0;
    endtask

    task automatic collect(input int budget);
        got.delete();
        rows.delete();
        done_seen = 1'b0;
        done_arr  = 1'b0;
        done_cyc  = 0;
        op_if.op_ready = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            if (rows.size() == 0 || rows[$] != int'(row_num))
                rows.push_back(int'(row_num));
            if (op_if.op_valid && op_if.op_ready)
                got.push_back(op_if.op);
            if (aln_done) begin
                done_seen = 1'b1;
                done_cyc  = c;
                done_arr  = aln_array;
                chk("busy_low_at_done", int'(tb_busy), 0);
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", int'(done_seen), 1);
    endtask

    // Expected ops packed two bits each, first op in bits [1:0].
    task automatic chk_ops(input string tag, input int n,
                           input logic [31:0] e);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size())
                chk({tag, "_op"}, int'(got[i]), int'(e[2*i +: 2]));
        end
    endtask

    initial begin
        logic [1:0]    s_op;
        logic [AW-1:0] s_row;
        bit            seen;

        clear_mem();
        op_if.op_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(tb_busy), 0);
        chk("rst_valid", int'(op_if.op_valid), 0);
        chk("rst_done", int'(aln_done), 0);
        chk("rst_arr", int'(aln_array), 0);
        chk("rst_blk", int'(mem_block_num), 0);
        chk("rst_row", int'(row_num), 0);
        reset_i = 1'b1;

        // Pure diagonal
        start(2, 2, 1'b1);
        collect(60);
        chk_ops("diag", 3, 32'h0);
        chk("diag_arr", int'(done_arr), 1);
        chk("diag_rows", rows.size(), 3);
        @(negedge clk);
        chk("diag_pulse", int'(aln_done), 0);
        chk("diag_arr_clr", int'(aln_array), 0);

        // Immediate STOP
        dm[2][2] = 7'd5;
        start(2, 2, 1'b0);
        collect(20);
        chk("stop_ops", got.size(), 0);
        chk("stop_latency", int'(done_cyc <= 4), 1);
        chk("stop_arr", int'(done_arr), 0);

        // F1 gap crossing from block 1 into block 0
        clear_mem();
        dm[5][3] = 7'h12;
        dm[4][3] = 7'h10;
        dm[2][3] = 7'd5;
        start(3, 5, 1'b1);
        collect(60);
        chk_ops("vgap", 3, 32'h2a);
        chk("vgap_arr", int'(done_arr), 1);
        chk("vgap_reads", rows.size(), 1);
        chk("vgap_blk", int'(mem_block_num), 1);
        chk("vgap_row", int'(row_num), 3);

        // Backpressure on the first op
        clear_mem();
        op_if.op_ready = 1'b0;
        start(2, 2, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (op_if.op_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("bp_valid_seen", int'(seen), 1);
        s_op  = op_if.op;
        s_row = row_num;
        chk("bp_first_op", int'(s_op), 0);
        chk("bp_first_row", int'(s_row), 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(op_if.op_valid), 1);
            chk("bp_hold_op", int'(op_if.op), int'(s_op));
            chk("bp_hold_row", int'(row_num), int'(s_row));
        end
        collect(60);
        chk_ops("bp", 3, 32'h0);

        // E2 gap along x, then diagonal
        clear_mem();
        dm[1][4] = 7'h23;
        dm[1][3] = 7'h20;
        start(4, 1, 1'b0);
        collect(80);
        chk_ops("hgap", 5, 32'h15);
        chk("hgap_nrows", rows.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rows.size())
                chk("hgap_row", rows[i], 4 - i);
        end

        // Request during a walk is ignored
        clear_mem();
        op_if.op_ready = 1'b0;
        start(3, 3, 1'b1);
        @(negedge clk);
        tb_x      = '0;
        tb_y      = '0;
        array_num = 1'b0;
        tb_valid  = 1'b1;
        @(negedge clk);
        tb_valid  = 1'b0;
        collect(80);
        chk_ops("ignore", 4, 32'h0);
        chk("ignore_arr", int'(done_arr), 1);

        // Reset mid-walk aborts; a later request still walks
        op_if.op_ready = 1'b0;
        start(2, 2, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (op_if.op_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort_valid_seen", int'(seen), 1);
        chk("abort_busy_before", int'(tb_busy), 1);
        reset_i = 1'b0;
        #1;
        chk("abort_busy", int'(tb_busy), 0);
        chk("abort_valid", int'(op_if.op_valid), 0);
        chk("abort_done", int'(aln_done), 0);
        @(negedge clk);
        reset_i = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (aln_done) seen = 1'b1;
        end
        chk("abort_no_done", int'(seen), 0);
        start(1, 1, 1'b0);
        collect(60);
        chk_ops("after_rst", 2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
